// File: rtl/shift_share_arbiter_if.sv
// Bundle of the two requester handshakes and the response handshake that
// connect the test drivers to the shared shifter.
interface shift_share_arbiter_if #(
  parameter int N = 3
);
  localparam int W = 2**N;

  // Requester 0
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [N-1:0] req0_amt;
  logic         req0_lr;

  // Requester 1
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [N-1:0] req1_amt;
  logic         req1_lr;

  // Response
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_y;
  logic         resp_id;

  // Driver side: issues operations and consumes results.
  modport master (
    output req0_valid, req0_a, req0_amt, req0_lr,
    input  req0_ready,
    output req1_valid, req1_a, req1_amt, req1_lr,
    input  req1_ready,
    input  resp_valid, resp_y, resp_id,
    output resp_ready
  );

  // Arbiter side: accepts operations and produces results.
  modport slave (
    input  req0_valid, req0_a, req0_amt, req0_lr,
    output req0_ready,
    input  req1_valid, req1_a, req1_amt, req1_lr,
    output req1_ready,
    output resp_valid, resp_y, resp_id,
    input  resp_ready
  );
endinterface

// File: rtl/shift_share_arbiter.sv
// Two-requester round-robin front end for a single left/right logical
// shifter. One operation is granted per cycle, shifted combinationally and
// captured in a one-entry result register with valid/ready backpressure.
module shift_share_arbiter #(
  parameter int N     = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_share_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]      grant_cnt0,
  output logic [CNT_W-1:0]      grant_cnt1
);

  localparam int W = 2**N;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Logical zero-fill shift; lr=1 shifts right, lr=0 shifts left and
  // drops bits pushed past the top.
  function automatic logic [W-1:0] dshift(input logic [W-1:0] a,
                                          input logic [N-1:0] amt,
                                          input logic         lr);
    logic [W-1:0] r;
    if (lr) r = a >> amt;
    else    r = a << amt;
    return r;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    if (&c) r = c;
    else    r = c + {{(CNT_W-1){1'b0}}, 1'b1};
    return r;
  endfunction

  state_t       state_q, state_d;
  logic         last_grant;
  logic         can_accept;
  logic         any_req_p0;
  logic         grant_id_p0;
  logic         accept_p0;
  logic [W-1:0] a_p0;
  logic [N-1:0] amt_p0;
  logic         lr_p0;
  logic [W-1:0] y_p0;
  logic [W-1:0] y_p1;
  logic         id_p1;
  logic         vld_p1;

  // ---- stage p0: arbitration, operand select and shift ----

  // Round-robin pick from current valids; ties go to whoever did not win last.
  always_comb begin
    can_accept  = (state_q == EMPTY) | bus.resp_ready;
    any_req_p0  = bus.req0_valid | bus.req1_valid;
    grant_id_p0 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant_id_p0 = ~last_grant;
    else if (bus.req1_valid)              grant_id_p0 = 1'b1;
    accept_p0   = can_accept & any_req_p0 & ~reset;
  end

  // Steer the granted operands into the shared shifter.
  always_comb begin
    a_p0   = bus.req0_a;
    amt_p0 = bus.req0_amt;
    lr_p0  = bus.req0_lr;
    if (grant_id_p0) begin
      a_p0   = bus.req1_a;
      amt_p0 = bus.req1_amt;
      lr_p0  = bus.req1_lr;
    end
    y_p0 = dshift(a_p0, amt_p0, lr_p0);
  end

  assign bus.req0_ready = accept_p0 & ~grant_id_p0;
  assign bus.req1_ready = accept_p0 &  grant_id_p0;

  // Result-register occupancy: fill on accept, drain when consumed idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept_p0) state_d = FULL;
      FULL:  if (!accept_p0 && bus.resp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // ---- stage p1: result register ----

  // Capture the shifted result and its owner only on an accepted grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_p1  <= '0;
      id_p1 <= 1'b0;
    end else if (accept_p0) begin
      y_p1  <= y_p0;
      id_p1 <= grant_id_p0;
    end
  end

  // Round-robin pointer and per-requester grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept_p0) begin
      last_grant <= grant_id_p0;
      if (grant_id_p0) grant_cnt1 <= sat_inc(grant_cnt1);
      else             grant_cnt0 <= sat_inc(grant_cnt0);
    end
  end

  assign vld_p1         = (state_q == FULL);
  assign bus.resp_valid = vld_p1;
  assign bus.resp_y     = y_p1;
  assign bus.resp_id    = id_p1;

endmodule
